// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared size/state encodings and beat-count helpers for the MIPS memory bridge
package mips_mem_pkg;

    // Access size as driven by the controller; 3 behaves like a word
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Bridge FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    function automatic int size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 1;
            SZ_HALF: return 2;
            default: return 4;
        endcase
    endfunction

    // A sub-bus-width access still needs one beat
    function automatic int size_beats(input logic [1:0] size, input int bpb);
        int n;
        n = size_bytes(size) / bpb;
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/mips_mem_timeout.sv
// rtl/mips_mem_timeout.sv - per-beat wait counter that flags a beat stuck without ack
module mips_mem_timeout #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Count ack-less cycles of the current beat; clr restarts for the next beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    // Fires on the LIMIT-th waiting cycle; the caller lets a same-cycle ack win
    assign expired = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mips_mem_bridge.sv
// rtl/mips_mem_bridge.sv - splits one core load/store into DATA_W-wide memory beats with wait/timeout
module mips_mem_bridge
    import mips_mem_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int BPB    = DATA_W / 8;
    localparam int NB_MAX = WORD_W / DATA_W;
    localparam int KW     = (NB_MAX > 1) ? $clog2(NB_MAX) : 1;

    logic [1:0]        state;
    logic              wr_l;
    logic [1:0]        size_l;
    logic [KW-1:0]     k;
    logic [WORD_W-1:0] wsh;
    logic [WORD_W-1:0] asm_r;
    logic [WORD_W-1:0] asm_next;
    logic [WORD_W-1:0] rmask;
    logic              last_beat;
    logic              tmo_expired;
    logic              tmo_clr;
    logic              tmo_en;

    assign last_beat = (k == KW'(size_beats(size_l, BPB) - 1));
    assign tmo_en    = (state == ST_ACCESS) && !mem_ack;
    assign tmo_clr   = (state != ST_ACCESS) || mem_ack;

    // Merge the current read beat into the assembly word at lane k
    always_comb begin
        asm_next = asm_r;
        asm_next[k*DATA_W +: DATA_W] = mem_rdata;
    end

    // Keep only the bytes the access size asked for (wide-bus narrow reads)
    always_comb begin
        case (size_l)
            SZ_BYTE: rmask = WORD_W'(8'hFF);
            SZ_HALF: rmask = WORD_W'(16'hFFFF);
            default: rmask = '1;
        endcase
    end

    generate
        if (TIMEOUT > 0) begin : g_tmo
            mips_mem_timeout #(.LIMIT(TIMEOUT)) u_tmo (
                .clk     (clk),
                .reset   (reset),
                .clr     (tmo_clr),
                .en      (tmo_en),
                .expired (tmo_expired)
            );
        end else begin : g_no_tmo
            assign tmo_expired = 1'b0;
        end
    endgenerate

    // Request/beat/response sequencer; every mem_* and rsp_* output is a flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_l      <= 1'b0;
            size_l    <= SZ_BYTE;
            k         <= '0;
            wsh       <= '0;
            asm_r     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_l      <= req_write;
                        size_l    <= req_size;
                        k         <= '0;
                        asm_r     <= '0;
                        wsh       <= req_wdata >> DATA_W;
                        mem_en    <= 1'b1;
                        mem_we    <= req_write;
                        mem_addr  <= req_addr;
                        mem_wdata <= req_wdata[DATA_W-1:0];
                        req_ready <= 1'b0;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        if (!wr_l) begin
                            asm_r <= asm_next;
                        end
                        if (last_beat) begin
                            mem_en    <= 1'b0;
                            mem_we    <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= wr_l ? '0 : (asm_next & rmask);
                            state     <= ST_RESP;
                        end else begin
                            k         <= k + KW'(1);
                            mem_addr  <= mem_addr + ADDR_W'(BPB);
                            mem_wdata <= wsh[DATA_W-1:0];
                            wsh       <= wsh >> DATA_W;
                        end
                    end else if (tmo_expired) begin
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= wr_l ? '0 : (asm_r & rmask);
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_bridge.sv
// tb/tb_mips_mem_bridge.sv - directed vector bench for mips_mem_bridge (8-bit and 16-bit bus)
module tb_mips_mem_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid8, req_valid16, req_write, rsp_ready;
    logic [1:0]  req_size;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;

    logic        req_ready8, rsp_valid8, rsp_err8, mem_en8, mem_we8, mem_ack8;
    logic [31:0] rsp_rdata8;
    logic [7:0]  mem_addr8, mem_wdata8, mem_rdata8;

    logic        req_ready16, rsp_valid16, rsp_err16, mem_en16, mem_we16, mem_ack16;
    logic [31:0] rsp_rdata16;
    logic [7:0]  mem_addr16;
    logic [15:0] mem_wdata16, mem_rdata16;

    mips_mem_bridge #(.DATA_W(8), .ADDR_W(8), .WORD_W(32), .TIMEOUT(8)) u8 (
        .clk(clk), .reset(rst),
        .req_valid(req_valid8), .req_ready(req_ready8), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata8), .rsp_err(rsp_err8),
        .mem_en(mem_en8), .mem_we(mem_we8), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8),
        .mem_ack(mem_ack8), .mem_rdata(mem_rdata8)
    );

    mips_mem_bridge #(.DATA_W(16), .ADDR_W(8), .WORD_W(32), .TIMEOUT(0)) u16 (
        .clk(clk), .reset(rst),
        .req_valid(req_valid16), .req_ready(req_ready16), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid16), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata16), .rsp_err(rsp_err16),
        .mem_en(mem_en16), .mem_we(mem_we16), .mem_addr(mem_addr16), .mem_wdata(mem_wdata16),
        .mem_ack(mem_ack16), .mem_rdata(mem_rdata16)
    );

    // 8-bit memory: ack after delay8 wait cycles on each beat
    logic [7:0] mem8 [256];
    int         wcnt8 = 0;
    int         delay8 = 0;
    assign mem_ack8    = mem_en8 && (wcnt8 == delay8);
    assign mem_rdata8  = mem8[mem_addr8];
    assign mem_ack16   = mem_en16;
    assign mem_rdata16 = 16'hA55A;

    always @(posedge clk) begin
        if (mem_en8 && !mem_ack8) wcnt8 <= wcnt8 + 1;
        else wcnt8 <= 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
            mem8[8'h10] = 8'h8C; mem8[8'h11] = 8'h03; mem8[8'h12] = 8'h00; mem8[8'h13] = 8'h44;
            mem8[8'hFE] = 8'h11; mem8[8'hFF] = 8'h22; mem8[8'h00] = 8'h33; mem8[8'h01] = 8'h44;
        end else if (mem_en8 && mem_we8 && mem_ack8) begin
            mem8[mem_addr8] = mem_wdata8;
        end
    end

    // Beat log of acked beats plus an address-hold monitor on the 8-bit port
    logic [7:0]  log_addr [256];
    logic [15:0] log_data [256];
    logic [7:0]  log_n = 8'd0;
    int          hold_err = 0;
    logic        prev_wait = 1'b0;
    logic [7:0]  prev_addr = 8'd0;

    always @(posedge clk) begin
        if (mem_en8 && mem_ack8) begin
            log_addr[log_n] = mem_addr8; log_data[log_n] = {8'h00, mem_wdata8}; log_n = log_n + 8'd1;
        end else if (mem_en16 && mem_ack16) begin
            log_addr[log_n] = mem_addr16; log_data[log_n] = mem_wdata16; log_n = log_n + 8'd1;
        end
        if (prev_wait && mem_en8 && (mem_addr8 != prev_addr)) hold_err++;
        prev_wait = mem_en8 && !mem_ack8;
        prev_addr = mem_addr8;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sel;
        logic        wr;
        logic [1:0]  size;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_beats;
    } vec_t;

    vec_t vt [14];

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0]  base;
        logic [7:0]  nb;
        logic [31:0] bmask;
        int          lat;
        int          bpb;
        bpb   = v.sel ? 2 : 1;
        bmask = v.sel ? 32'hFFFF : 32'hFF;
        @(negedge clk);
        delay8 = v.delay; req_write = v.wr; req_size = v.size; req_addr = v.addr; req_wdata = v.wdata;
        chk($sformatf("v%0d req_ready_idle", idx), v.sel ? req_ready16 : req_ready8, 1);
        base = log_n;
        if (v.sel) req_valid16 = 1'b1; else req_valid8 = 1'b1;
        @(posedge clk); #1;
        req_valid8 = 1'b0; req_valid16 = 1'b0;
        lat = 1;
        while (!(v.sel ? rsp_valid16 : rsp_valid8) && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d rsp_rdata", idx), v.sel ? rsp_rdata16 : rsp_rdata8, v.exp_rdata);
        chk($sformatf("v%0d rsp_err", idx), v.sel ? rsp_err16 : rsp_err8, v.exp_err);
        chk($sformatf("v%0d mem_en_resp", idx), v.sel ? mem_en16 : mem_en8, 0);
        chk($sformatf("v%0d req_ready_busy", idx), v.sel ? req_ready16 : req_ready8, 0);
        nb = log_n - base;
        chk($sformatf("v%0d beats", idx), nb, v.exp_beats);
        for (int b = 0; b < v.exp_beats && b < int'(nb); b++) begin
            chk($sformatf("v%0d beat%0d addr", idx, b), log_addr[8'(base + b)], 8'(v.addr + b * bpb));
            if (v.wr) chk($sformatf("v%0d beat%0d wdata", idx, b), log_data[8'(base + b)],
                          (v.wdata >> (8 * b * bpb)) & bmask);
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        chk($sformatf("v%0d rsp_valid_clear", idx), v.sel ? rsp_valid16 : rsp_valid8, 0);
        chk($sformatf("v%0d req_ready_back", idx), v.sel ? req_ready16 : req_ready8, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] base;
        //          sel  wr    size   addr   wdata          dly  rdata          err  lat beats
        vt[0]  = '{1'b0, 1'b0, 2'd2, 8'h10, 32'h0,          0,   32'h4400038C, 1'b0, 5,  4};
        vt[1]  = '{1'b0, 1'b1, 2'd2, 8'h20, 32'hDEADBEEF,   0,   32'h0,        1'b0, 5,  4};
        vt[2]  = '{1'b0, 1'b0, 2'd2, 8'h20, 32'h0,          0,   32'hDEADBEEF, 1'b0, 5,  4};
        vt[3]  = '{1'b0, 1'b0, 2'd2, 8'hFE, 32'h0,          0,   32'h44332211, 1'b0, 5,  4};
        vt[4]  = '{1'b0, 1'b0, 2'd2, 8'hFE, 32'h0,          2,   32'h44332211, 1'b0, 13, 4};
        vt[5]  = '{1'b0, 1'b0, 2'd0, 8'h11, 32'h0,          0,   32'h00000003, 1'b0, 2,  1};
        vt[6]  = '{1'b0, 1'b0, 2'd1, 8'h12, 32'h0,          1,   32'h00004400, 1'b0, 5,  2};
        vt[7]  = '{1'b0, 1'b1, 2'd1, 8'h30, 32'hFFFF1234,   0,   32'h0,        1'b0, 3,  2};
        vt[8]  = '{1'b0, 1'b0, 2'd3, 8'h10, 32'h0,          0,   32'h4400038C, 1'b0, 5,  4};
        vt[9]  = '{1'b0, 1'b0, 2'd2, 8'h10, 32'h0,          7,   32'h4400038C, 1'b0, 33, 4};
        vt[10] = '{1'b0, 1'b0, 2'd2, 8'h10, 32'h0,          100, 32'h0,        1'b1, 9,  0};
        vt[11] = '{1'b1, 1'b0, 2'd1, 8'h40, 32'h0,          0,   32'h0000A55A, 1'b0, 2,  1};
        vt[12] = '{1'b1, 1'b0, 2'd0, 8'h40, 32'h0,          0,   32'h0000005A, 1'b0, 2,  1};
        vt[13] = '{1'b1, 1'b0, 2'd2, 8'h40, 32'h0,          0,   32'hA55AA55A, 1'b0, 3,  2};

        rst = 1'b1; req_valid8 = 1'b0; req_valid16 = 1'b0; req_write = 1'b0;
        req_size = 2'd0; req_addr = 8'h00; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready", req_ready8, 1);
        chk("rst rsp_valid", rsp_valid8, 0);
        chk("rst rsp_err", rsp_err8, 0);
        chk("rst rsp_rdata", rsp_rdata8, 0);
        chk("rst mem_en", mem_en8, 0);
        chk("rst mem_we", mem_we8, 0);
        chk("rst mem_addr", mem_addr8, 0);
        chk("rst mem_wdata", mem_wdata8, 0);
        chk("rst16 req_ready", req_ready16, 1);
        chk("rst16 mem_en", mem_en16, 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(i, vt[i]);
        chk("addr_hold_while_waiting", hold_err, 0);

        // Response held off for 4 cycles; a request during RESP must be ignored
        @(negedge clk);
        delay8 = 0; req_write = 1'b0; req_size = 2'd0; req_addr = 8'h10; req_valid8 = 1'b1;
        @(posedge clk); #1; req_valid8 = 1'b0;
        lat = 1;
        while (!rsp_valid8 && lat < 60) begin @(posedge clk); #1; lat++; end
        chk("hold latency", lat, 2);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); req_valid8 = 1'b1; req_addr = 8'h13;
            @(posedge clk); #1;
            chk($sformatf("hold%0d rsp_valid", c), rsp_valid8, 1);
            chk($sformatf("hold%0d rsp_rdata", c), rsp_rdata8, 32'h0000008C);
            chk($sformatf("hold%0d req_ready", c), req_ready8, 0);
            chk($sformatf("hold%0d mem_en", c), mem_en8, 0);
        end
        @(negedge clk); req_valid8 = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        chk("hold release rsp_valid", rsp_valid8, 0);
        @(posedge clk); #1;
        chk("hold no_stray_beat", mem_en8, 0);

        // Reset during beat 2 of a waited word read
        @(negedge clk);
        delay8 = 2; req_write = 1'b0; req_size = 2'd2; req_addr = 8'h10; req_valid8 = 1'b1;
        @(posedge clk); #1; req_valid8 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst mem_en_before", mem_en8, 1);
        chk("midrst mem_addr_before", mem_addr8, 8'h12);
        rst = 1'b1;
        #1;
        chk("midrst req_ready", req_ready8, 1);
        chk("midrst rsp_valid", rsp_valid8, 0);
        chk("midrst rsp_err", rsp_err8, 0);
        chk("midrst rsp_rdata", rsp_rdata8, 0);
        chk("midrst mem_en", mem_en8, 0);
        chk("midrst mem_we", mem_we8, 0);
        chk("midrst mem_addr", mem_addr8, 0);
        chk("midrst mem_wdata", mem_wdata8, 0);
        base = log_n;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst no_beats", 8'(log_n - base), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst req_ready_after", req_ready8, 1);
        chk("midrst mem_en_after", mem_en8, 0);
        run_vec(100, vt[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_mem_bridge.md
Name: mips_mem_bridge

Overview:
- Parametrised memory-port adapter for the multicycle MIPS core family. Replaces fixed 4-cycle byte-lane instruction assembly with a generic engine.
- Converts one WORD_W-bit load/store request (byte, half or word) into a sequence of DATA_W-wide memory beats. Supports memory wait states via an ack handshake and a per-beat timeout that returns an error.
- Sits between the controller/datapath and the external memory bus; the result is returned on a valid/ready response channel.

Parameters:
- DATA_W, 8, memory bus width in bits; 8, 16 or 32; must divide WORD_W.
- ADDR_W, 8, byte-address width.
- WORD_W, 32, core word width.
- TIMEOUT, 0, max cycles waiting for mem_ack per beat; 0 = never time out.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request (IDLE only).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_addr  in  ADDR_W  byte address of the first byte.
- req_wdata  in  WORD_W  store data, little-endian.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  WORD_W  load data, zero-extended; 0 for stores.
- rsp_err  out  1  timeout occurred.
- mem_en  out  1  beat request.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  beat byte address.
- mem_wdata  out  DATA_W  beat write data.
- mem_ack  in  1  memory completes the beat this cycle.
- mem_rdata  in  DATA_W  read data, valid when mem_ack is high.

Behaviour:
- Reset values:
  - req_ready = 1.
  - rsp_valid, rsp_err, mem_en, mem_we = 0.
  - mem_addr, mem_wdata, rsp_rdata = 0.
  - State = IDLE.
- Reset asserted mid-operation: the access is abandoned immediately and no further beats are issued. Partial writes already acked remain in memory.
- Derived values:
  - BPB = DATA_W/8 bytes per beat.
  - nbytes = 1/2/4 by req_size.
  - nbeats = max(1, nbytes/BPB).
- All mem_* and rsp_* outputs are registered.
- IDLE: req_ready = 1. On req_valid:
  - Latch write, size, addr and wdata; clear the assembly register and beat index k.
  - Go to ACCESS. mem_en rises the next cycle, so request-to-first-beat latency is 1 cycle.
- ACCESS: mem_en = 1, mem_we = latched write.
  - mem_addr = addr + k*BPB, modulo 2^ADDR_W (wraps).
  - mem_wdata = latched wdata bits [k*DATA_W +: DATA_W].
  - Outputs hold steady until mem_ack.
  - On mem_ack for a read: mem_rdata is written into assembly bits [k*DATA_W +: DATA_W]. Bits beyond nbytes*8 are masked to 0.
  - On mem_ack with k < nbeats-1: increment k and issue the next beat in the next cycle. With zero-wait memory (ack same cycle as en), beats are back-to-back.
  - On mem_ack for the last beat: go to RESP, mem_en = 0.
- Timeout (TIMEOUT > 0): a wait counter clears on entry to each beat and increments each ACCESS cycle without ack.
  - When the counter reaches TIMEOUT and ack is still low: go to RESP with rsp_err = 1 and mem_en = 0. Remaining beats are not issued; bytes not received read as 0.
  - An ack arriving in the same cycle as the limit wins, and no error is raised.
- RESP: rsp_valid = 1; rsp_rdata and rsp_err are held stable while rsp_ready = 0.
  - On rsp_ready: go to IDLE; rsp_valid and rsp_err clear.
- Word read latency, zero wait states, DATA_W=8: rsp_valid asserts 5 cycles after request acceptance.
- req_valid outside IDLE is ignored (req_ready = 0). No pipelining: one outstanding request.
- mem_ack while not in ACCESS is ignored.

Decomposition:
- Shared package mips_mem_pkg:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - State encoding IDLE/ACCESS/RESP.
  - Function for beats-per-size.
- One natural sub-module: mips_mem_timeout, the per-beat wait counter with clear/enable inputs and an expired output. It is elided when TIMEOUT = 0.

Test Plan:
- DATA_W=8, zero-wait memory with bytes 0x10..0x13 = 8C,03,00,44; word read at 0x10 -> beats at 0x10..0x13, rsp_rdata = 0x4400038C, rsp_err = 0, rsp_valid 5 cycles after accept.
- Word store 0xDEADBEEF at 0x20 -> mem_we beats EF@0x20, BE@0x21, AD@0x22, DE@0x23; response rsp_rdata = 0.
- Word read at 0xFE -> mem_addr sequence FE, FF, 00, 01 (wrap). Same read with mem_ack delayed 2 cycles per beat -> mem_addr and mem_en held 3 cycles each, correct data.
- TIMEOUT=8, mem_ack never asserted, word read -> after 8 waiting cycles on beat 0, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, mem_en = 0. Ack on exactly the 8th cycle -> no error.
- DATA_W=16, half read at 0x40 with mem_rdata = 0xA55A -> 1 beat, rsp_rdata = 0x0000A55A. Byte read -> rsp_rdata = 0x0000005A.
- rsp_ready held low 4 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0. reset pulsed during beat 2 of a word read -> all outputs return to reset values immediately, req_ready = 1 after release.
